// File: rtl/display_scan_pkg.sv
// Shared constants and helpers for the six-digit multiplexed 7-segment scanner.
// Segment vectors are active-high internally, bit0 = segment a.
package display_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef logic [2:0] digit_idx_t;

    // Out-of-range fields and non-decimal nibbles both render as a dash.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit, input logic valid);
        logic [6:0] pat;
        pat = SEG_DASH;
        if (valid) begin
            case (digit)
                4'd0:    pat = SEG_DIGIT[0];
                4'd1:    pat = SEG_DIGIT[1];
                4'd2:    pat = SEG_DIGIT[2];
                4'd3:    pat = SEG_DIGIT[3];
                4'd4:    pat = SEG_DIGIT[4];
                4'd5:    pat = SEG_DIGIT[5];
                4'd6:    pat = SEG_DIGIT[6];
                4'd7:    pat = SEG_DIGIT[7];
                4'd8:    pat = SEG_DIGIT[8];
                4'd9:    pat = SEG_DIGIT[9];
                default: pat = SEG_DASH;
            endcase
        end else begin
            pat = SEG_DASH;
        end
        return pat;
    endfunction

endpackage

// File: rtl/display_scan_if.sv
// Time-word input and multiplexed display pins of the scanner.
interface display_scan_if;
    logic [23:0] data_in;
    logic [2:0]  blink_mask;
    logic        dp_en;
    logic [6:0]  seg;
    logic        dp;
    logic [5:0]  dig;

    modport master (output data_in, output blink_mask, output dp_en,
                    input  seg, input dp, input dig);
    modport slave  (input  data_in, input blink_mask, input dp_en,
                    output seg, output dp, output dig);
endinterface

// File: rtl/display_scan_bcd_split.sv
// Splits an 8-bit binary field into decimal tens/units; valid only for 0..99.
module bcd_split (
    input  logic [7:0] i_value,
    output logic [3:0] o_tens,
    output logic [3:0] o_units,
    output logic       o_valid
);

    // Largest multiple of ten not above the value selects tens and remainder.
    always_comb begin
        o_tens  = 4'd0;
        o_units = i_value[3:0];
        for (int k = 1; k < 10; k++) begin
            if (i_value >= 8'(k * 10)) begin
                o_tens  = 4'(k);
                o_units = 4'(i_value - 8'(k * 10));
            end else begin
                o_tens  = o_tens;
                o_units = o_units;
            end
        end
        o_valid = (i_value <= 8'd99);
    end

endmodule

// File: rtl/display_scan.sv
// Six-digit 7-segment scanner for a {hour, min, sec} time word with
// per-frame snapshot, per-field blinking and separator dots.
module display_scan
    import display_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_FRAMES   = 83,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic           clock,
    input  logic           reset,
    display_scan_if.slave  bus
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    // XOR masks that turn internal active-high values into pin levels.
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW ? 1'b1  : 1'b0;
    localparam logic [5:0] DIG_OFF = DIG_ACTIVE_LOW ? 6'h3F : 6'h00;

    logic [PW-1:0] r_presc;
    logic          r_started;
    digit_idx_t    r_idx;
    logic [23:0]   r_snap;
    logic [2:0]    r_mask;
    logic [FW-1:0] r_frame;
    logic          r_phase;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic [5:0]    r_dig;

    logic          w_tick;
    digit_idx_t    w_idx_nxt;
    logic          w_load;
    logic          w_frame_end;
    logic [FW-1:0] w_frame_nxt;
    logic          w_phase_nxt;
    logic [23:0]   w_data;
    logic [2:0]    w_mask;
    logic [3:0]    w_tens [3];
    logic [3:0]    w_units [3];
    logic          w_valid [3];
    logic [3:0]    w_digit;
    logic          w_dvalid;
    logic          w_blank;
    logic [6:0]    w_seg;
    logic          w_dp;
    logic [5:0]    w_dig;

    assign w_tick      = (r_presc == PW'(SCAN_DIV - 1));
    assign w_load      = w_tick && (w_idx_nxt == 3'd0);
    assign w_frame_end = w_tick && r_started && (r_idx == 3'd5);
    // Digit 0 of a new frame decodes straight from the live inputs.
    assign w_data      = w_load ? bus.data_in    : r_snap;
    assign w_mask      = w_load ? bus.blink_mask : r_mask;

    // Next digit index; the first tick after reset always lands on digit 0.
    always_comb begin
        w_idx_nxt = r_idx;
        if (!r_started) begin
            w_idx_nxt = 3'd0;
        end else if (r_idx == 3'd5) begin
            w_idx_nxt = 3'd0;
        end else begin
            w_idx_nxt = r_idx + 3'd1;
        end
    end

    // Blink frame counter; the new phase is used for the whole new frame.
    always_comb begin
        w_frame_nxt = r_frame;
        w_phase_nxt = r_phase;
        if (w_frame_end) begin
            if (r_frame == FW'(BLINK_FRAMES - 1)) begin
                w_frame_nxt = '0;
                w_phase_nxt = ~r_phase;
            end else begin
                w_frame_nxt = r_frame + FW'(1);
            end
        end else begin
            w_frame_nxt = r_frame;
        end
    end

    bcd_split u_bcd_sec  (.i_value(w_data[7:0]),   .o_tens(w_tens[0]), .o_units(w_units[0]), .o_valid(w_valid[0]));
    bcd_split u_bcd_min  (.i_value(w_data[15:8]),  .o_tens(w_tens[1]), .o_units(w_units[1]), .o_valid(w_valid[1]));
    bcd_split u_bcd_hour (.i_value(w_data[23:16]), .o_tens(w_tens[2]), .o_units(w_units[2]), .o_valid(w_valid[2]));

    // Select the field digit for the upcoming slot and decide blanking.
    always_comb begin
        w_digit  = 4'd0;
        w_dvalid = 1'b0;
        w_blank  = 1'b1;
        case (w_idx_nxt)
            3'd0: begin w_digit = w_units[0]; w_dvalid = w_valid[0]; w_blank = w_phase_nxt & w_mask[0]; end
            3'd1: begin w_digit = w_tens[0];  w_dvalid = w_valid[0]; w_blank = w_phase_nxt & w_mask[0]; end
            3'd2: begin w_digit = w_units[1]; w_dvalid = w_valid[1]; w_blank = w_phase_nxt & w_mask[1]; end
            3'd3: begin w_digit = w_tens[1];  w_dvalid = w_valid[1]; w_blank = w_phase_nxt & w_mask[1]; end
            3'd4: begin w_digit = w_units[2]; w_dvalid = w_valid[2]; w_blank = w_phase_nxt & w_mask[2]; end
            3'd5: begin w_digit = w_tens[2];  w_dvalid = w_valid[2]; w_blank = w_phase_nxt & w_mask[2]; end
            default: begin w_digit = 4'd0; w_dvalid = 1'b0; w_blank = 1'b1; end
        endcase
        w_seg = w_blank ? SEG_BLANK : seg_encode(w_digit, w_dvalid);
        w_dp  = ~w_blank & bus.dp_en & ((w_idx_nxt == 3'd2) || (w_idx_nxt == 3'd4));
        w_dig = 6'd1 << w_idx_nxt;
    end

    // Prescaler, scan position, snapshot, blink state and registered pins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_presc   <= '0;
            r_started <= 1'b0;
            r_idx     <= 3'd0;
            r_snap    <= 24'd0;
            r_mask    <= 3'd0;
            r_frame   <= '0;
            r_phase   <= 1'b0;
            r_seg     <= SEG_OFF;
            r_dp      <= DP_OFF;
            r_dig     <= DIG_OFF;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            r_frame <= w_frame_nxt;
            r_phase <= w_phase_nxt;
            if (w_load) begin
                r_snap <= bus.data_in;
                r_mask <= bus.blink_mask;
            end
            if (w_tick) begin
                r_started <= 1'b1;
                r_idx     <= w_idx_nxt;
                r_seg     <= w_seg ^ SEG_OFF;
                r_dp      <= w_dp ^ DP_OFF;
                r_dig     <= w_dig ^ DIG_OFF;
            end
        end
    end

    assign bus.seg = r_seg;
    assign bus.dp  = r_dp;
    assign bus.dig = r_dig;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan: active-low instance with SCAN_DIV=4,
// BLINK_FRAMES=2, plus an active-high instance for pin polarity.
module tb_display_scan;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    display_scan_if bus_lo ();
    display_scan_if bus_hi ();

    display_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1))
        u_dut_lo (.clock(clk), .reset(rst_n), .bus(bus_lo));
    display_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0))
        u_dut_hi (.clock(clk), .reset(rst_n), .bus(bus_hi));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Active-high segment patterns, bit0 = a; anything else is a dash.
    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    task automatic next_slot();
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Checks one full frame of the active-low instance; optionally changes
    // data_in right after slot chg_slot has been sampled.
    task automatic check_frame(input logic [23:0] d, input logic [2:0] mask, input logic phase,
                               input logic dpen, input int chg_slot, input logic [23:0] chg_data,
                               input string tag);
        for (int s = 0; s < 6; s++) begin
            int         v;
            logic       blank;
            logic       lit;
            logic [6:0] es;
            logic [6:0] seg_pin;
            logic [5:0] dig_pin;
            next_slot();
            v     = (s < 2) ? int'(d[7:0]) : (s < 4) ? int'(d[15:8]) : int'(d[23:16]);
            blank = phase && mask[s / 2];
            if (blank)       es = 7'h00;
            else if (v > 99) es = 7'h40;
            else             es = pat((s % 2 == 1) ? v / 10 : v % 10);
            lit     = dpen && (s == 2 || s == 4) && !blank;
            seg_pin = ~es;
            dig_pin = ~(6'd1 << s);
            check_val($sformatf("%s d%0d dig", tag, s), {26'd0, bus_lo.dig}, {26'd0, dig_pin});
            check_val($sformatf("%s d%0d seg", tag, s), {25'd0, bus_lo.seg}, {25'd0, seg_pin});
            check_val($sformatf("%s d%0d dp",  tag, s), {31'd0, bus_lo.dp},  {31'd0, ~lit});
            if (s == 0) begin
                check_val($sformatf("%s hi dig", tag), {26'd0, bus_hi.dig}, 32'h01);
                check_val($sformatf("%s hi seg", tag), {25'd0, bus_hi.seg}, 32'h7F);
                check_val($sformatf("%s hi dp",  tag), {31'd0, bus_hi.dp},  32'h0);
            end
            if (s == chg_slot) bus_lo.data_in = chg_data;
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        bus_lo.data_in    = {8'd23, 8'd59, 8'd7};
        bus_lo.blink_mask = 3'b000;
        bus_lo.dp_en      = 1'b1;
        bus_hi.data_in    = {8'd0, 8'd0, 8'd8};
        bus_hi.blink_mask = 3'b000;
        bus_hi.dp_en      = 1'b0;
        #12;
        check_val("rst lo dig", {26'd0, bus_lo.dig}, 32'h3F);
        check_val("rst lo seg", {25'd0, bus_lo.seg}, 32'h7F);
        check_val("rst lo dp",  {31'd0, bus_lo.dp},  32'h1);
        check_val("rst hi dig", {26'd0, bus_hi.dig}, 32'h00);
        check_val("rst hi seg", {25'd0, bus_hi.seg}, 32'h00);
        check_val("rst hi dp",  {31'd0, bus_hi.dp},  32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        check_frame({8'd23, 8'd59, 8'd7}, 3'b000, 1'b0, 1'b1, -1, 24'd0, "f1");
        check_frame({8'd23, 8'd59, 8'd7}, 3'b000, 1'b0, 1'b1, 3, {8'd0, 8'd0, 8'd8}, "f2 tear");
        check_frame({8'd0, 8'd0, 8'd8}, 3'b000, 1'b1, 1'b1, -1, 24'd0, "f3");

        bus_lo.data_in = {8'd0, 8'd120, 8'd8};
        check_frame({8'd0, 8'd120, 8'd8}, 3'b000, 1'b1, 1'b1, -1, 24'd0, "f4 range");

        bus_lo.data_in    = {8'd23, 8'd59, 8'd7};
        bus_lo.blink_mask = 3'b100;
        check_frame({8'd23, 8'd59, 8'd7}, 3'b100, 1'b0, 1'b1, -1, 24'd0, "f5 blink");
        check_frame({8'd23, 8'd59, 8'd7}, 3'b100, 1'b0, 1'b1, -1, 24'd0, "f6 blink");
        check_frame({8'd23, 8'd59, 8'd7}, 3'b100, 1'b1, 1'b1, -1, 24'd0, "f7 blink");
        check_frame({8'd23, 8'd59, 8'd7}, 3'b100, 1'b1, 1'b1, -1, 24'd0, "f8 blink");
        check_frame({8'd23, 8'd59, 8'd7}, 3'b100, 1'b0, 1'b1, -1, 24'd0, "f9 blink");

        // Reset in the middle of a frame, then restart from digit 0.
        next_slot();
        next_slot();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("mid rst lo dig", {26'd0, bus_lo.dig}, 32'h3F);
        check_val("mid rst lo seg", {25'd0, bus_lo.seg}, 32'h7F);
        check_val("mid rst lo dp",  {31'd0, bus_lo.dp},  32'h1);
        check_val("mid rst hi dig", {26'd0, bus_hi.dig}, 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("restart early dig", {26'd0, bus_lo.dig}, 32'h3F);
        @(posedge clk);
        #1;
        check_val("restart dig", {26'd0, bus_lo.dig}, 32'h3E);
        check_val("restart seg", {25'd0, bus_lo.seg}, 32'h78);
        check_val("restart dp",  {31'd0, bus_lo.dp},  32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/display_scan.md
Name: display_scan

Overview:
- Downstream consumer of the stopwatch/clock time word: converts the 24-bit {hour, min, sec} binary field word into six multiplexed 7-segment digits.
- Drives one digit at a time at a fixed refresh rate.
- Snapshots the time word once per frame so a digit pair never tears mid-scan.
- Supports per-field blinking for setup modes and static separator dots.

Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot (1 kHz digit rate at 50 MHz); must be >= 2.
- BLINK_FRAMES, 83, completed frames per blink half-period (about 0.5 s at defaults).
- SEG_ACTIVE_LOW, 1, 1 = seg/dp are low-active; 0 = high-active.
- DIG_ACTIVE_LOW, 1, 1 = dig enables are low-active; 0 = high-active.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- data_in  input  24  [7:0] sec, [15:8] min, [23:16] hour; each field is unsigned binary
- blink_mask  input  3  bit0 sec, bit1 min, bit2 hour; 1 = blank that field during the blink-off phase
- dp_en  input  1  1 = light the separator dots on digits 2 and 4
- seg  output  7  segments a..g, with bit0 = a
- dp  output  1  decimal point
- dig  output  6  one-hot digit enable; bit i = digit index i

Behaviour:
- Reset (async, reset=0):
  - All outputs are inactive: seg, dp and dig are all off at the configured polarity.
  - Prescaler = 0, index = 0, started = 0, snapshot = 0, frame count = 0, blink phase = 0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick = 1 for exactly one cycle, when the count equals SCAN_DIV-1.
  - Width is $clog2(SCAN_DIV).
- Index advance, on tick only:
  - If started = 0: set started = 1 and new index = 0.
  - Otherwise: new index = 0 if the old index is 5, else old index + 1.
- Snapshot:
  - On a tick whose new index = 0, load data_in and blink_mask into the snapshot registers.
  - The digit-0 outputs on that same tick decode directly from data_in and blink_mask (bypass), not from the old snapshot.
- Digit map:
  - 0 = sec units, 1 = sec tens
  - 2 = min units, 3 = min tens
  - 4 = hour units, 5 = hour tens
- Decode per field:
  - Field value v in 0..99: tens = v/10, units = v%10. Both digits are always shown; no leading-zero blanking.
  - Field value v > 99: both digits of that field show a dash (segment g only).
- Blink:
  - The frame count increments on each tick where the old index is 5 and started = 1.
  - When the frame count reaches BLINK_FRAMES-1, it clears and the blink phase toggles.
  - While phase = 1 and the snapshot mask bit for a field is 1, both digits of that field output seg all off and dp off. dig still pulses, so scan timing is unchanged.
- dp:
  - On for digit indices 2 and 4 when dp_en = 1 (sampled live), unless that digit is blanked.
  - Off for all other digits.
- Outputs:
  - seg, dp and dig are registered and update only on tick, so each output value is held for exactly SCAN_DIV cycles.
  - Latency from a tick to the new digit on the pins is 1 clock.
  - dig has exactly one bit active at all times after the first tick.
- Boundary conditions:
  - data_in changing mid-frame has no visible effect until the next index-0 slot.
  - Reset asserted mid-frame returns all outputs to inactive immediately; scanning restarts from index 0 on the first tick after reset release.
  - A blink_mask change mid-frame takes effect at the next frame.
  - Polarity parameters invert only the pin values; internal logic is active-high.

Decomposition:
- Shared package display_pkg:
  - NUM_DIGITS = 6
  - 7-bit segment constants SEG_DIGIT[0:9], SEG_DASH = 7'b1000000, SEG_BLANK = 7'b0000000
  - typedef digit_idx_t (3-bit)
- Sub-module bcd_split (combinational):
  - Input: 8-bit value.
  - Outputs: 4-bit tens, 4-bit units, valid (value <= 99).
  - Instantiated three times, once per field.

Test Plan (SCAN_DIV=4, BLINK_FRAMES=2, active-low pins):
- Reset check: assert reset mid-scan -> same cycle dig=6'b111111, seg=7'b1111111, dp=1. Release -> first dig=6'b111110 appears 4 clocks later, then the active digit advances every 4 clocks 0..5 and wraps.
- Digit decode: data_in = {8'd23, 8'd59, 8'd7}, mask=0, dp_en=1 -> in scan order, digits show 7,0,9,5,3,2 with segment patterns per the package constants. dp is low (lit) only on digits 2 and 4.
- Tearing: change data_in to {8'd0, 8'd0, 8'd8} while digit 3 is active -> digits 3..5 keep the old 5,3,2; the next frame shows 8,0,0,0,0,0.
- Out-of-range field: min field = 8'd120 -> digits 2 and 3 show seg=7'b0111111 (dash only); the other fields decode normally.
- Blink: blink_mask=3'b100 -> hour digits lit for 2 frames, blank (seg=7'b1111111) for 2 frames, repeating. sec and min digits are unaffected. dig still cycles through all 6 digits.
- Polarity: SEG_ACTIVE_LOW=0 and DIG_ACTIVE_LOW=0 -> reset gives dig=0 and seg=0; digit 0 with value 8 gives dig=6'b000001 and seg=7'b1111111.
